// File: rtl/inst_rom.sv
// rtl/inst_rom.sv - 8-word registered instruction ROM indexed by pc[4:2]
// Define INST_ROM_PARITY_EN to add the registered inst_par output (XOR of the fetched word).
module inst_rom #(
    parameter int              DATA_W     = 32,
    parameter int              ADDR_W     = 5,
    parameter logic [DATA_W-1:0] RESET_INST = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] inst,
    output logic              addr_err
`ifdef INST_ROM_PARITY_EN
    ,
    output logic              inst_par
`endif
);

    localparam int DEPTH = 1 << (ADDR_W - 2);

    // Fixed program image; pc[1:0] never participates in word selection.
    localparam logic [DATA_W-1:0] ROM [DEPTH] = '{
        32'h2001_0005,
        32'h2002_0003,
        32'h0022_1820,
        32'h0022_2022,
        32'h0022_2824,
        32'h0022_3025,
        32'h0022_382A,
        32'hAC03_0000
    };

    logic [ADDR_W-3:0] word_idx;
    logic [DATA_W-1:0] rom_word;
    logic [DATA_W-1:0] inst_d, inst_q;
    logic              addr_err_d, addr_err_q;

    assign word_idx = pc[ADDR_W-1:2];
    assign rom_word = ROM[word_idx];

    always_comb begin
        inst_d     = inst_q;
        addr_err_d = addr_err_q;
        if (ce) begin
            inst_d     = rom_word;
            addr_err_d = |pc[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_q     <= RESET_INST;
            addr_err_q <= 1'b0;
        end else begin
            inst_q     <= inst_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign inst     = inst_q;
    assign addr_err = addr_err_q;

`ifdef INST_ROM_PARITY_EN
    logic inst_par_d, inst_par_q;

    always_comb begin
        inst_par_d = inst_par_q;
        if (ce) begin
            inst_par_d = ^rom_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_par_q <= 1'b0;
        end else begin
            inst_par_q <= inst_par_d;
        end
    end

    assign inst_par = inst_par_q;
`endif

endmodule

// File: tb/tb_inst_rom.sv
// tb/tb_inst_rom.sv - directed and randomized bench for inst_rom against a table model
module tb_inst_rom;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [4:0]  pc;
    logic [31:0] inst;
    logic        addr_err;
`ifdef INST_ROM_PARITY_EN
    logic        inst_par;
`endif

    always #5 clk = ~clk;

    inst_rom dut (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .pc       (pc),
        .inst     (inst),
        .addr_err (addr_err)
`ifdef INST_ROM_PARITY_EN
        ,
        .inst_par (inst_par)
`endif
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] words [8] = '{
        32'h2001_0005, 32'h2002_0003, 32'h0022_1820, 32'h0022_2022,
        32'h0022_2824, 32'h0022_3025, 32'h0022_382A, 32'hAC03_0000
    };

    logic [31:0] m_inst;
    logic        m_err;
    logic        m_par;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply inputs, take one rising edge, then advance the reference model.
    task automatic tick(input logic r, input logic c, input logic [4:0] p);
        int idx;
        rst = r;
        ce  = c;
        pc  = p;
        @(posedge clk);
        #1;
        idx = int'(p) / 4;
        if (r) begin
            m_inst = 32'h0;
            m_err  = 1'b0;
            m_par  = 1'b0;
        end else if (c) begin
            m_inst = words[idx];
            m_err  = (int'(p) % 4) != 0;
            m_par  = 1'(($countones(words[idx])) % 2);
        end
    endtask

    task automatic check_model(input string tag);
        check_eq({tag, "_inst"}, inst, m_inst);
        check_eq({tag, "_err"}, {31'b0, addr_err}, {31'b0, m_err});
`ifdef INST_ROM_PARITY_EN
        check_eq({tag, "_par"}, {31'b0, inst_par}, {31'b0, m_par});
`endif
    endtask

    initial begin
        m_inst = 32'h0;
        m_err  = 1'b0;
        m_par  = 1'b0;

        // Reset dominates ce
        tick(1'b1, 1'b1, 5'd8);
        tick(1'b1, 1'b1, 5'd8);
        check_eq("rst_inst", inst, 32'h0000_0000);
        check_eq("rst_err", {31'b0, addr_err}, 32'h0);
        tick(1'b0, 1'b1, 5'd8);
        check_eq("post_rst_inst", inst, 32'h0022_1820);

        // Successive fetches, one-cycle latency
        tick(1'b0, 1'b1, 5'd0);
        check_eq("seq0", inst, 32'h2001_0005);
        tick(1'b0, 1'b1, 5'd4);
        check_eq("seq4", inst, 32'h2002_0003);
        tick(1'b0, 1'b1, 5'd8);
        check_eq("seq8", inst, 32'h0022_1820);
        check_eq("seq_err", {31'b0, addr_err}, 32'h0);

        // Full aligned sweep
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b1, 5'(i * 4));
            check_model("sweep");
        end
        check_eq("sweep_last", inst, 32'hAC03_0000);

        // Misaligned then aligned
        tick(1'b0, 1'b1, 5'd5);
        check_eq("mis_inst", inst, 32'h2002_0003);
        check_eq("mis_err", {31'b0, addr_err}, 32'h1);
        tick(1'b0, 1'b1, 5'd12);
        check_eq("al_inst", inst, 32'h0022_2022);
        check_eq("al_err", {31'b0, addr_err}, 32'h0);

        // Hold with ce low
        tick(1'b0, 1'b1, 5'd24);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 5'd0);
            check_eq("hold_inst", inst, 32'h0022_382A);
        end
        tick(1'b0, 1'b1, 5'd0);
        check_eq("resume_inst", inst, 32'h2001_0005);

`ifdef INST_ROM_PARITY_EN
        check_eq("par0", {31'b0, inst_par}, 32'h0);
        tick(1'b0, 1'b1, 5'd8);
        check_eq("par8", {31'b0, inst_par}, 32'h1);
        tick(1'b1, 1'b0, 5'd8);
        check_eq("par_rst", {31'b0, inst_par}, 32'h0);
`endif

        // Randomized traffic against the table model
        tick(1'b1, 1'b0, 5'd0);
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7), 5'($urandom_range(0, 31)));
            check_model("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
